des_arb_ctrl: RTL

Round-robin controller that shares one DES core between two independent requesters. It accepts a 64-bit block, a key and an encrypt/decrypt flag from each requester over valid/ready, then sequences the core's key/data load. It waits out the 16 rounds, captures the result and returns it to the originating requester over valid/ready. A watchdog recovers the core if it never signals completion.

---
 rtl/des_ctrl_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 14 +
 rtl/des_arb_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the two-requester DES controller.
package des_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_RESP,
    ST_RECOVER
  } state_e;

  // Rounds performed by the DES core per block.
  localparam int DES_ROUNDS = 16;

  // Distance in cycles from the ISSUE cycle to the nominal Dvld pulse.
  localparam int DES_NOM_LAT = DES_ROUNDS + 1;

  // Default watchdog limit, counted from the ISSUE cycle.
  localparam int TO_CYCLES_DEF = 32;

  // Width of a counter able to hold the watchdog limit.
  function automatic int wd_width(input int to_cycles);
    return $clog2(to_cycles + 1);
  endfunction

  localparam int WD_W = wd_width(TO_CYCLES_DEF);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: with both requesters valid the one not
// granted last wins, otherwise the single valid requester is granted.
module rr_arb2 (
  input  logic last_grant_i,
  input  logic vld0_i,
  input  logic vld1_i,
  output logic gnt_vld_o,
  output logic gnt_idx_o
);

  assign gnt_vld_o = vld0_i | vld1_i;
  assign gnt_idx_o = (vld0_i & vld1_i) ? ~last_grant_i : vld1_i;

endmodule

// File: rtl/des_arb_ctrl.sv
// Round-robin controller sharing one DES core between two requesters,
// with a watchdog that resets the core if it never signals completion.
module des_arb_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  // requester 0
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [1:64] req0_din,
  input  logic [1:64] req0_key,
  input  logic        req0_enc,
  output logic        rsp0_vld,
  input  logic        rsp0_rdy,
  output logic [1:64] rsp0_dout,
  output logic        rsp0_err,
  // requester 1
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [1:64] req1_din,
  input  logic [1:64] req1_key,
  input  logic        req1_enc,
  output logic        rsp1_vld,
  input  logic        rsp1_rdy,
  output logic [1:64] rsp1_dout,
  output logic        rsp1_err,
  // DES core side
  output logic [1:64] des_din,
  output logic [1:64] des_key,
  output logic        des_drdy,
  output logic        des_krdy,
  output logic        des_enc,
  output logic        des_en,
  output logic        des_rstn,
  input  logic [1:64] des_dout,
  input  logic        des_bsy,
  input  logic        des_dvld
);

  localparam int CNT_W = wd_width(TO_CYCLES);
  // cnt_q counts BUSY cycles already spent; the BUSY cycle seeing this
  // value is TO_CYCLES-1 cycles after ISSUE, the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 2);

  state_e           state_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [1:64]      din_q;
  logic [1:64]      key_q;
  logic             enc_q;
  logic [1:64]      dout_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             drdy_q;
  logic [1:0]       rsp_vld_q;
  logic             recover_q;

  logic gnt_vld;
  logic gnt_idx;
  logic accept_d;
  logic rsp_hs_d;

  // Core busy is informational only; completion is taken from Dvld.
  logic unused_bsy;
  assign unused_bsy = des_bsy;

  rr_arb2 u_arb (
    .last_grant_i (last_grant_q),
    .vld0_i       (req0_vld),
    .vld1_i       (req1_vld),
    .gnt_vld_o    (gnt_vld),
    .gnt_idx_o    (gnt_idx)
  );

  assign accept_d = (state_q == ST_IDLE) && !RST && gnt_vld;
  assign rsp_hs_d = (state_q == ST_RESP) && (grant_q ? rsp1_rdy : rsp0_rdy);
  assign cnt_d    = cnt_q + 1'b1;

  assign req0_rdy = accept_d && !gnt_idx;
  assign req1_rdy = accept_d &&  gnt_idx;

  // Controller FSM: accept, issue to core, wait/watchdog, respond.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      din_q        <= '0;
      key_q        <= '0;
      enc_q        <= 1'b0;
      dout_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      drdy_q       <= 1'b0;
      rsp_vld_q    <= 2'b00;
      recover_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            grant_q <= gnt_idx;
            din_q   <= gnt_idx ? req1_din : req0_din;
            key_q   <= gnt_idx ? req1_key : req0_key;
            enc_q   <= gnt_idx ? req1_enc : req0_enc;
            drdy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          drdy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (des_dvld) begin
            dout_q             <= des_dout;
            err_q              <= 1'b0;
            rsp_vld_q[grant_q] <= 1'b1;
            state_q            <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            dout_q    <= '0;
            err_q     <= 1'b1;
            recover_q <= 1'b1;
            state_q   <= ST_RECOVER;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RECOVER: begin
          recover_q          <= 1'b0;
          rsp_vld_q[grant_q] <= 1'b1;
          state_q            <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs_d) begin
            rsp_vld_q    <= 2'b00;
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign des_din   = din_q;
  assign des_key   = key_q;
  assign des_enc   = enc_q;
  assign des_drdy  = drdy_q;
  assign des_krdy  = drdy_q;
  assign des_en    = ~RST;
  assign des_rstn  = ~RST & ~recover_q;

  assign rsp0_vld  = rsp_vld_q[0];
  assign rsp1_vld  = rsp_vld_q[1];
  assign rsp0_dout = dout_q;
  assign rsp1_dout = dout_q;
  assign rsp0_err  = err_q;
  assign rsp1_err  = err_q;

endmodule
